uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2_000_000, the tx_done wait limit in clk cycles (used only under REQ-030).
REQ-003 SHALL have port clk  input  1  the single rising-edge clock for all state.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  NREQ  per-requester byte-valid.
REQ-006 SHALL have port req_data_i  input  8*NREQ  per-requester byte; requester k occupies bits [8k+7:8k].
REQ-007 SHALL have port req_ready_o  output  NREQ  per-requester accept strobe.
REQ-008 SHALL have port tx_din_o  output  8  byte to the uart_tx din_i.
REQ-009 SHALL have port tx_start_o  output  1  start strobe to the uart_tx tx_start_i.
REQ-010 SHALL have port tx_done_i  input  1  one-cycle done pulse from the uart_tx tx_done_o.
REQ-011 SHALL have port grant_o  output  NREQ  one-hot current owner; zero when idle.
REQ-012 SHALL have port busy_o  output  1  high whenever state is not S_IDLE.
REQ-013 SHALL have port timeout_o  output  1  one-cycle timeout error pulse.

Function
REQ-014 SHALL implement the states S_IDLE, S_START and S_WAIT.
REQ-015 In S_IDLE, the block SHALL combinationally drive req_ready_o high only for the round-robin winner among the asserted req_valid_i bits, with all other bits low.
REQ-016 Round-robin search SHALL start at (last+1) mod NREQ, where last is the previously granted index (NREQ-1 after reset, so requester 0 has first priority).
REQ-017 A transfer SHALL occur only in a cycle where req_valid_i[k] and req_ready_o[k] are both high; on that edge the block SHALL register the byte into tx_din_o, set grant_o to one-hot k, set last to k, and enter S_START.
REQ-018 In S_START, tx_start_o SHALL be high for exactly one cycle, after which the state SHALL become S_WAIT.
REQ-019 tx_din_o SHALL be held stable from the accept edge until the block next returns to S_IDLE.
REQ-020 In S_WAIT, tx_done_i high SHALL return the state to S_IDLE, clear grant_o, and make the next accept possible in that same S_IDLE cycle (one idle cycle between frames).
REQ-021 tx_done_i SHALL be ignored in S_IDLE and S_START.
REQ-022 req_ready_o SHALL be all-zero outside S_IDLE; a requester holding req_valid_i SHALL keep waiting, and dropping req_valid_i before accept SHALL produce no transfer.
REQ-023 Under continuous requests from all requesters, grants SHALL rotate 0,1,...,NREQ-1,0 with no starvation.
REQ-024 A single active requester SHALL be granted on every frame.
REQ-025 tx_start_o SHALL never be asserted outside S_START.

Reset
REQ-026 With rst_ni low at a clk edge, the block SHALL enter S_IDLE and force tx_start_o=0, tx_din_o=0, grant_o=0, busy_o=0 and timeout_o=0, with last=NREQ-1 and the timeout counter at 0.
REQ-027 A reset taken mid-frame SHALL abandon the owner without a retry, and a later tx_done_i SHALL be ignored per REQ-021.
REQ-028 req_ready_o SHALL be all-zero while rst_ni is low.

Configuration
REQ-029 The block SHALL provide the macro UART_TX_ARB_TIMEOUT_EN.
REQ-030 With UART_TX_ARB_TIMEOUT_EN defined, a 32-bit counter SHALL clear on entry to S_WAIT and increment each S_WAIT cycle; on reaching TIMEOUT_CYC-1 without tx_done_i, the block SHALL pulse timeout_o for one cycle, enter S_IDLE and clear grant_o, and last SHALL stay at the timed-out index.
REQ-031 With UART_TX_ARB_TIMEOUT_EN undefined, no counter SHALL exist, timeout_o SHALL be constant 0, and S_WAIT SHALL exit only on tx_done_i.

Verification
REQ-032 Bench: reset, then req_valid_i=4'b0001 with byte 0x55 -> req_ready_o[0] high in the same cycle, tx_start_o high one cycle later, tx_din_o=0x55, grant_o=4'b0001.
REQ-033 Bench: req_valid_i=4'b1111 held with bytes 0xA0..0xA3, done pulsed 20 cycles after each start -> tx_din_o sequence 0xA0,0xA1,0xA2,0xA3,0xA0.
REQ-034 Bench: after granting requester 2, req_valid_i=4'b0101 -> requester 0 is granted next (search starts at 3).
REQ-035 Bench: tx_done_i pulsed during S_START -> ignored, state remains S_WAIT until a later done pulse.
REQ-036 Bench: rst_ni low for one cycle in S_WAIT -> S_IDLE next cycle, grant_o=0, and the following tx_done_i is ignored.
REQ-037 Bench: with the macro defined, TIMEOUT_CYC=50 and no done -> timeout_o pulses 50 cycles after S_WAIT entry and busy_o then drops; without the macro, busy_o stays high.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-requester and uart_tx handshake bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport; requesters/uart_tx drive the master side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [7:0]        tx_din_o;
    logic              tx_start_o;
    logic              tx_done_i;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;
    logic              timeout_o;

    modport slave (
        input  req_valid_i, req_data_i, tx_done_i,
        output req_ready_o, tx_din_o, tx_start_o, grant_o, busy_o, timeout_o
    );

    modport master (
        output req_valid_i, req_data_i, tx_done_i,
        input  req_ready_o, tx_din_o, tx_start_o, grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into a single uart_tx.
// Define UART_TX_ARB_TIMEOUT_EN to abandon a frame whose tx_done never arrives.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input logic               clk,
    input logic               rst_ni,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic [NREQ-1:0] ready;
    logic [NREQ-1:0] grant_q;
    logic [7:0]      din_q;
    logic [7:0]      win_byte;
    logic            accept;
    logic            timeout_hit;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("uart_tx_arbiter: NREQ must be 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
    end

    // Search starts one past the previous owner and wraps, so the last owner is tried last.
    always_comb begin
        logic [IW-1:0] cand;
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(last_q) + i) % NREQ);
            if (!win_found && bus.req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IW'(k) == win_idx) begin
                win_byte = bus.req_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == S_IDLE && rst_ni && win_found) begin
            ready[win_idx] = 1'b1;
        end
    end

    assign accept = |(ready & bus.req_valid_i);

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [31:0] cnt_q;
    logic        timeout_q;

    assign timeout_hit = (state_q == S_WAIT) && !bus.tx_done_i
                         && (cnt_q == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state_q == S_START) begin
                cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (bus.tx_done_i || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NREQ - 1);
            grant_q <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                din_q   <= win_byte;
                grant_q <= ready;
                last_q  <= win_idx;
            end else if (state_q == S_WAIT && state_d == S_IDLE) begin
                grant_q <= '0;
            end
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.tx_din_o    = din_q;
    assign bus.tx_start_o  = (state_q == S_START);
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4, TIMEOUT_CYC=50).
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(4)) bus ();

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT_CYC(50)) dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic [7:0]  din;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first valid requester after the previous owner, wrapping.
    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int off = 1; off <= 4; off++) begin
            if (v[(last + off) % 4]) return (last + off) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_ni          = 1'b0;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.tx_done_i   = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        #1;
        chk("rst_busy",    32'(bus.busy_o), 0);
        chk("rst_grant",   32'(bus.grant_o), 0);
        chk("rst_din",     32'(bus.tx_din_o), 0);
        chk("rst_start",   32'(bus.tx_start_o), 0);
        chk("rst_timeout", 32'(bus.timeout_o), 0);
        chk("rst_ready",   32'(bus.req_ready_o), 0);
    endtask

    // One frame from an idle cycle: offer v/d, then hold v through the frame.
    task automatic frame(input string tag, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] exp_rdy, input logic [7:0] exp_din, input int wait_cyc);
        bus.req_valid_i = v;
        bus.req_data_i  = d;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'(exp_rdy));
        if (exp_rdy == 4'b0000) begin
            step();
            chk({tag, "_idle_busy"}, 32'(bus.busy_o), 0);
            return;
        end
        step();
        chk({tag, "_start"}, 32'(bus.tx_start_o), 1);
        chk({tag, "_din"},   32'(bus.tx_din_o), 32'(exp_din));
        chk({tag, "_grant"}, 32'(bus.grant_o), 32'(exp_rdy));
        chk({tag, "_rdy_start"}, 32'(bus.req_ready_o), 0);
        step();
        chk({tag, "_start_one"}, 32'(bus.tx_start_o), 0);
        chk({tag, "_busy_wait"}, 32'(bus.busy_o), 1);
        chk({tag, "_rdy_wait"},  32'(bus.req_ready_o), 0);
        repeat (wait_cyc) step();
        chk({tag, "_din_hold"},  32'(bus.tx_din_o), 32'(exp_din));
        bus.tx_done_i = 1'b1;
        step();
        bus.tx_done_i = 1'b0;
        chk({tag, "_busy_done"},  32'(bus.busy_o), 0);
        chk({tag, "_grant_done"}, 32'(bus.grant_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        logic [7:0]  rr_exp[5];
        int          seen, pulses, busy_at, mlast, win;
        logic [3:0]  v, erdy;
        logic [31:0] d;
        logic [7:0]  edin;

        tbl[0] = '{v: 4'b0001, d: 32'h0000_0055, rdy: 4'b0001, din: 8'h55};
        tbl[1] = '{v: 4'b0101, d: 32'hD3C2_B1A0, rdy: 4'b0100, din: 8'hC2};
        tbl[2] = '{v: 4'b0101, d: 32'hD3C2_B1A0, rdy: 4'b0001, din: 8'hA0};
        tbl[3] = '{v: 4'b1111, d: 32'hD3C2_B1A0, rdy: 4'b0010, din: 8'hB1};
        tbl[4] = '{v: 4'b1001, d: 32'hD3C2_B1A0, rdy: 4'b1000, din: 8'hD3};
        tbl[5] = '{v: 4'b1000, d: 32'hD3C2_B1A0, rdy: 4'b1000, din: 8'hD3};
        tbl[6] = '{v: 4'b0110, d: 32'hD3C2_B1A0, rdy: 4'b0010, din: 8'hB1};
        tbl[7] = '{v: 4'b0000, d: 32'hD3C2_B1A0, rdy: 4'b0000, din: 8'h00};
        rr_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            frame($sformatf("row%0d", i), tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].din, 3);
        end

        // All four requesters held: grants rotate and wrap to 0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            frame($sformatf("rot%0d", i), 4'b1111, 32'hA3A2_A1A0, 4'(1 << (i % 4)), rr_exp[i], 19);
        end

        // tx_done during S_START and in S_IDLE is ignored.
        do_reset();
        bus.req_valid_i = 4'b0010;
        bus.req_data_i  = 32'h0000_7700;
        #1;
        chk("dstart_ready", 32'(bus.req_ready_o), 32'b0010);
        step();
        bus.req_valid_i = '0;
        bus.tx_done_i   = 1'b1;
        chk("dstart_start", 32'(bus.tx_start_o), 1);
        step();
        bus.tx_done_i = 1'b0;
        chk("dstart_busy", 32'(bus.busy_o), 1);
        repeat (3) step();
        chk("dstart_busy_later", 32'(bus.busy_o), 1);
        bus.tx_done_i = 1'b1;
        step();
        bus.tx_done_i = 1'b0;
        chk("dstart_exit", 32'(bus.busy_o), 0);
        bus.tx_done_i = 1'b1;
        step();
        bus.tx_done_i = 1'b0;
        chk("didle_busy",  32'(bus.busy_o), 0);
        chk("didle_start", 32'(bus.tx_start_o), 0);

        // Reset in S_WAIT abandons the frame; a later done does nothing.
        bus.req_valid_i = 4'b0100;
        bus.req_data_i  = 32'h0033_0000;
        #1;
        chk("mrst_ready", 32'(bus.req_ready_o), 32'b0100);
        step();
        bus.req_valid_i = '0;
        step();
        chk("mrst_wait_busy", 32'(bus.busy_o), 1);
        rst_ni          = 1'b0;
        bus.req_valid_i = 4'b0010;
        #1;
        chk("mrst_ready_in_rst", 32'(bus.req_ready_o), 0);
        step();
        rst_ni          = 1'b1;
        bus.req_valid_i = '0;
        chk("mrst_busy",  32'(bus.busy_o), 0);
        chk("mrst_grant", 32'(bus.grant_o), 0);
        chk("mrst_din",   32'(bus.tx_din_o), 0);
        chk("mrst_start", 32'(bus.tx_start_o), 0);
        bus.tx_done_i = 1'b1;
        step();
        bus.tx_done_i = 1'b0;
        chk("mrst_done_busy",  32'(bus.busy_o), 0);
        chk("mrst_done_grant", 32'(bus.grant_o), 0);
        bus.req_valid_i = 4'b0011;
        #1;
        chk("mrst_last", 32'(bus.req_ready_o), 32'b0001);
        bus.req_valid_i = '0;
        #1;

        // Missing tx_done: timeout with the macro, indefinite wait without.
        do_reset();
        bus.req_valid_i = 4'b1000;
        bus.req_data_i  = 32'h9900_0000;
        #1;
        chk("to_ready", 32'(bus.req_ready_o), 32'b1000);
        step();
        bus.req_valid_i = '0;
        step();
        seen    = -1;
        pulses  = 0;
        busy_at = -1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (bus.timeout_o) begin
                pulses++;
                if (seen < 0) begin
                    seen    = n;
                    busy_at = int'(bus.busy_o);
                end
            end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("to_cycle",  32'(seen), 50);
        chk("to_width",  32'(pulses), 1);
        chk("to_busy",   32'(busy_at), 0);
        chk("to_grant",  32'(bus.grant_o), 0);
        bus.req_valid_i = 4'b1001;
        #1;
        chk("to_last",   32'(bus.req_ready_o), 32'b0001);
        bus.req_valid_i = '0;
        #1;
`else
        chk("nto_pulses", 32'(pulses), 0);
        chk("nto_busy",   32'(bus.busy_o), 1);
        bus.tx_done_i = 1'b1;
        step();
        bus.tx_done_i = 1'b0;
        chk("nto_exit",   32'(bus.busy_o), 0);
`endif

        // Random traffic against the arbitration model.
        do_reset();
        mlast = 3;
        for (int it = 0; it < 60; it++) begin
            v    = 4'($urandom_range(0, 15));
            d    = $urandom;
            win  = rr_pick(v, mlast);
            erdy = (win < 0) ? 4'b0000 : 4'(1 << win);
            edin = (win < 0) ? 8'h00 : d[8*win +: 8];
            frame($sformatf("rnd%0d", it), v, d, erdy, edin, int'($urandom_range(0, 8)));
            if (win >= 0) mlast = win;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
